// File: rtl/sha_core_arbiter_if.sv
// Requester-side bundle of sha_core_arbiter: job handshake and digest response.
// master = requester side, slave = arbiter side.
interface sha_core_arbiter_if #(
    parameter int NUM_REQ  = 2,
    parameter int MSG_SIZE = 96
);
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*MSG_SIZE-1:0] req_msg;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ-1:0]          resp_valid;
    logic [255:0]                resp_hash;
    logic                        resp_err;

    modport master (
        output req_valid, req_msg,
        input  req_ready, resp_valid, resp_hash, resp_err
    );

    modport slave (
        input  req_valid, req_msg,
        output req_ready, resp_valid, resp_hash, resp_err
    );
endinterface

// File: rtl/sha_core_arbiter.sv
// Round-robin arbiter/sequencer sharing one sha_256 core between NUM_REQ requesters.
// Define SHA_ARB_TIMEOUT_EN to add a RUN watchdog that aborts a job with resp_err=1.
module sha_core_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int MSG_SIZE       = 96,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    sha_core_arbiter_if.slave   arb,
    output logic                busy,
    output logic [MSG_SIZE-1:0] core_msg,
    output logic                core_rst,
    input  logic [255:0]        core_hash,
    input  logic                core_done
);
    localparam int          IDX_W = $clog2(NUM_REQ);
    localparam int unsigned NREQ  = NUM_REQ;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    grant_idx, cand;
    logic [NUM_REQ-1:0]  grant, ready, resp_v;
    logic                found;
    logic [MSG_SIZE-1:0] msg_q, msg_d;
    logic [255:0]        hash_q, hash_d;
`ifdef SHA_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_nxt;
    logic                err_q, err_d;

    assign cnt_nxt = cnt_q + 1'b1;
`endif

    // Search starts one above the last owner and wraps, so nobody waits more than NUM_REQ-1 jobs.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDX_W'((32'(last_q) + k) % NREQ);
            if (!found && arb.req_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        grant = found ? (NUM_REQ'(1) << grant_idx) : '0;
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        msg_d    = msg_q;
        hash_d   = hash_q;
        ready    = '0;
        resp_v   = '0;
        core_rst = 1'b1;
`ifdef SHA_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (rst) ready = grant;
                if (rst && found) begin
                    msg_d   = arb.req_msg[grant_idx*MSG_SIZE +: MSG_SIZE];
                    owner_d = grant_idx;
                    state_d = LOAD;
                end
            end
            LOAD: begin
`ifdef SHA_ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
                state_d = RUN;
            end
            RUN: begin
                core_rst = 1'b0;
`ifdef SHA_ARB_TIMEOUT_EN
                cnt_d = cnt_nxt;
`endif
                // A done on the timeout edge still counts as success.
                if (core_done) begin
                    hash_d  = core_hash;
`ifdef SHA_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = RESP;
                end
`ifdef SHA_ARB_TIMEOUT_EN
                else if (cnt_nxt == CNT_W'(TIMEOUT_CYCLES)) begin
                    hash_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
`endif
            end
            RESP: begin
                resp_v  = NUM_REQ'(1) << owner_q;
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= IDX_W'(NUM_REQ - 1);
            owner_q <= '0;
            msg_q   <= '0;
            hash_q  <= '0;
`ifdef SHA_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            msg_q   <= msg_d;
            hash_q  <= hash_d;
`ifdef SHA_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign arb.req_ready  = ready;
    assign arb.resp_valid = resp_v;
    assign arb.resp_hash  = hash_q;
`ifdef SHA_ARB_TIMEOUT_EN
    assign arb.resp_err   = err_q;
`else
    assign arb.resp_err   = 1'b0;
`endif
    assign core_msg = msg_q;
    assign busy     = (state_q != IDLE);
endmodule

// File: doc/sha_core_arbiter.md
# sha_core_arbiter

Round-robin arbiter and sequencer that shares one `sha_256` hash core between `NUM_REQ` requesters, such as the ECDSA sign and verify engines. It accepts a message from one requester at a time and latches it onto the core's message input. It restarts the core by pulsing the core's reset, waits for the core's `done`, then returns the 256-bit digest to the requester that issued the job. The block sits between the signature engines and the single `sha_256` instance.

## Interface
- `NUM_REQ`, 2, number of requesters (≥2)
- `MSG_SIZE`, 96, message width; must match the core's `MSG_SIZE`
- `TIMEOUT_CYCLES`, 1024, watchdog limit in RUN cycles (used only with `SHA_ARB_TIMEOUT_EN`)

Ports:
- `clk` in 1 — single clock
- `rst` in 1 — asynchronous, active-low reset
- `req_valid` in NUM_REQ — requester i has a message pending
- `req_msg` in NUM_REQ*MSG_SIZE — requester i message at `[i*MSG_SIZE +: MSG_SIZE]`
- `req_ready` out NUM_REQ — one-hot grant; a handshake occurs on `req_valid[i] & req_ready[i]`
- `resp_valid` out NUM_REQ — one-cycle pulse to the owning requester
- `resp_hash` out 256 — digest; valid while `resp_valid` is nonzero
- `resp_err` out 1 — job aborted by watchdog; qualified by `resp_valid`
- `busy` out 1 — a job is in flight (state ≠ IDLE)
- `core_msg` out MSG_SIZE — drives the core's `message`
- `core_rst` out 1 — drives the core's `rst`; active-high, 1 holds the core in reset
- `core_hash` in 256 — core's `hashed`
- `core_done` in 1 — core's `done`

## Operation
- FSM states: IDLE, LOAD, RUN, RESP.
- **IDLE**
  - `core_rst`=1.
  - If any `req_valid` is set, `req_ready` = one-hot winner, combinational.
  - Priority starts at `last_grant+1` (mod NUM_REQ) and searches upward with wrap.
  - On the handshake edge: latch the message into `core_msg`, record the owner index, go to LOAD.
- **LOAD** (exactly 1 cycle)
  - `core_rst`=1 flushes the previous `done`; `core_msg` is stable. Go to RUN.
- **RUN**
  - `core_rst`=0; wait for `core_done`=1.
  - On the sampling edge: register `core_hash` into `resp_hash`, clear `resp_err`, go to RESP.
- **RESP** (exactly 1 cycle)
  - `resp_valid[owner]`=1.
  - `last_grant`←owner; go to IDLE with `core_rst`=1.
- `req_ready` is 0 in every state except IDLE. No requests are queued.
- `core_msg` and `resp_hash` hold their values until overwritten by the next job.
- There is no response backpressure. The requester must accept the response pulse.
- `req_valid` dropped before grant: no effect; the arbiter re-evaluates every IDLE cycle.
- Requesters not granted keep `req_valid` asserted and are served in rotation. Starvation bound: NUM_REQ−1 jobs.

## Timing
- Reset values:
  - state=IDLE
  - `last_grant`=NUM_REQ−1, so requester 0 has first priority
  - `core_rst`=1
  - `core_msg`=0, `resp_hash`=0, `resp_err`=0
  - `resp_valid`=0, `busy`=0
- `req_ready` is 0 during reset.
- Handshake at edge T:
  - LOAD during cycle T→T+1; RUN from T+1.
  - If `core_done` is first sampled high at edge D, `resp_valid` is high during cycle D→D+1.
  - Earliest next grant: cycle D+1→D+2.
- Overhead beyond core latency: 1 LOAD cycle + 1 RESP cycle + 1 IDLE cycle.
- `core_done` is ignored outside RUN.
- Reset asserted mid-job: immediate abort, no `resp_valid`, `core_rst`=1 asynchronously.

## Configuration
- `SHA_ARB_TIMEOUT_EN` defined:
  - A RUN-cycle counter of width $clog2(TIMEOUT_CYCLES+1) clears on LOAD.
  - If the counter reaches TIMEOUT_CYCLES with `core_done`=0: go to RESP with `resp_err`=1 and `resp_hash`=0.
  - `core_done` and timeout on the same edge: `core_done` wins and `resp_err`=0.
- `SHA_ARB_TIMEOUT_EN` undefined:
  - No counter; RUN waits indefinitely.
  - `resp_err` is tied to 0. The port list is unchanged.

## Test plan
The bench core model behaves as follows: `done` rises 10 cycles after `rst` falls, and `hashed` = {160'h0, msg}.
- **Single job:** req 0, msg 96'h616263 → `req_ready`=01 on the same cycle; `resp_valid`=01 exactly 13 cycles after the handshake edge; `resp_hash`=256'h616263; `resp_err`=0.
- **Round robin:** req 0 and req 1 both held high for 4 jobs → grant order 0,1,0,1; each `resp_valid` goes only to the owner with its own msg echoed.
- **Wrap, NUM_REQ=3:** only req 2 valid after a grant to 1 → grant 2; then all three valid → grant order 0,1,2.
- **Reset mid-RUN:** `rst`=0 five cycles into RUN → `core_rst`=1 and `busy`=0 immediately; no `resp_valid`; after release, req 0 is granted first.
- **Watchdog** (`SHA_ARB_TIMEOUT_EN`, TIMEOUT_CYCLES=16, core never finishes) → RESP after 16 RUN cycles with `resp_err`=1 and `resp_hash`=0. With `done` on cycle 16 → `resp_err`=0.
- **Stale done:** core model holds `done`=1 across IDLE → it is ignored; LOAD reset clears it, and the response arrives only after the new `done`.
